// File: rtl/calc_arith_sequencer.sv
// calc_arith_sequencer: multi-cycle add/sub/shift-add multiply/restoring divide around one shared adder.
// Define CALC_ARITH_OVF_EN to enable the oOVF flag (2W-bit multiply accumulator).
module calc_arith_sequencer #(
    parameter int W     = 24,
    parameter int CNT_W = 5
) (
    input  logic         clk,
    input  logic         iRST_n,
    input  logic         iSTART,
    input  logic [1:0]   iOP,
    input  logic [W-1:0] iA,
    input  logic [W-1:0] iB,
    output logic         oBUSY,
    output logic         oDONE,
    output logic [W-1:0] oRESULT,
    output logic [W-1:0] oREM,
    output logic         oDIV0,
    output logic         oOVF
);
`ifdef CALC_ARITH_OVF_EN
    localparam int ACC_W = 2 * W;
`else
    localparam int ACC_W = W;
`endif
    // two guard bits so the divide trial subtraction has an unambiguous sign bit
    localparam int AW = ACC_W + 2;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ADDSUB, S_MUL, S_DIV, S_DONE} state_t;
    state_t             r_state, w_next;
    logic [1:0]         r_op;
    logic [ACC_W-1:0]   r_a, r_acc;
    logic [W-1:0]       r_b, r_rem, r_q, r_res, r_rem_out;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done, r_div0, r_ovf;
    logic               w_accept, w_last, w_div0, w_sub, w_ge, w_ovf;
    logic [AW-1:0]      w_x, w_y, w_sum;

    assign w_accept = r_state == S_IDLE && !r_done && iSTART;
    assign w_last   = r_cnt == CNT_W'(W - 1);
    assign w_div0   = r_op == 2'b00 && r_b == '0;
    assign w_sub    = (r_state == S_ADDSUB && r_op == 2'b10) || r_state == S_DIV;
    assign w_x      = r_state == S_DIV ? AW'({r_rem, r_q[W-1]}) : r_state == S_MUL ? AW'(r_acc) : AW'(r_a);
    assign w_y      = r_state == S_MUL ? (r_b[0] ? AW'(r_a) : '0) : AW'(r_b);
    assign w_sum    = w_x + (w_sub ? ~w_y : w_y) + AW'(w_sub);
    assign w_ge     = !w_sum[AW-1];
`ifdef CALC_ARITH_OVF_EN
    // add: carry into bit W; sub: borrow leaves bit W set; mul: any high product bit
    assign w_ovf = r_op == 2'b00 ? 1'b0 : r_op == 2'b11 ? |r_acc[ACC_W-1:W] : r_acc[W];
`else
    assign w_ovf = 1'b0;
`endif

    assign oBUSY   = r_state != S_IDLE || r_done;
    assign oDONE   = r_done;
    assign oRESULT = r_res;
    assign oREM    = r_rem_out;
    assign oDIV0   = r_div0;
    assign oOVF    = r_ovf;

    always_ff @(posedge clk or negedge iRST_n) begin
        if (!iRST_n) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       w_next = w_accept ? S_LOAD : S_IDLE;
            S_LOAD:       w_next = w_div0 ? S_DONE : r_op == 2'b11 ? S_MUL : r_op == 2'b00 ? S_DIV : S_ADDSUB;
            S_ADDSUB:     w_next = S_DONE;
            S_MUL, S_DIV: w_next = w_last ? S_DONE : r_state;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge iRST_n) begin
        if (!iRST_n) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_res     <= '0;
            r_rem_out <= '0;
            r_div0    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op <= iOP;
                    r_a  <= ACC_W'(iA);
                    r_b  <= iB;
                    r_q  <= iA;
                end
                S_LOAD: begin
                    r_acc <= '0;
                    r_rem <= '0;
                    r_cnt <= '0;
                end
                S_ADDSUB: r_acc <= w_sum[ACC_W-1:0];
                S_MUL: begin
                    r_acc <= w_sum[ACC_W-1:0];
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_DIV: begin
                    // r_q shifts dividend bits out at the top and quotient bits in at the bottom
                    r_rem <= w_ge ? w_sum[W-1:0] : {r_rem[W-2:0], r_q[W-1]};
                    r_q   <= {r_q[W-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_DONE: begin
                    r_done    <= 1'b1;
                    r_res     <= w_div0 ? '1 : r_op == 2'b00 ? r_q : r_acc[W-1:0];
                    r_rem_out <= w_div0 ? r_a[W-1:0] : r_op == 2'b00 ? r_rem : '0;
                    r_div0    <= w_div0;
                    r_ovf     <= w_ovf;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_arith_sequencer.sv
// tb_calc_arith_sequencer: directed checks of latency, results, flags, start filtering and reset abort.
module tb_calc_arith_sequencer;
`ifdef CALC_ARITH_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif
    logic        clk = 1'b0, iRST_n = 1'b0, iSTART = 1'b0;
    logic [1:0]  iOP = 2'b00;
    logic [23:0] iA = '0, iB = '0;
    logic        oBUSY, oDONE, oDIV0, oOVF;
    logic [23:0] oRESULT, oREM;
    int          n_chk = 0, n_pass = 0;

    calc_arith_sequencer dut (
        .clk(clk), .iRST_n(iRST_n), .iSTART(iSTART), .iOP(iOP), .iA(iA), .iB(iB),
        .oBUSY(oBUSY), .oDONE(oDONE), .oRESULT(oRESULT), .oREM(oREM), .oDIV0(oDIV0), .oOVF(oOVF)
    );

    always #5 clk = ~clk;

    // Called at a negedge with the DUT idle; returns cycles from accept edge to oDONE.
    task automatic do_op(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b, output int lat);
        iSTART = 1'b1; iOP = op; iA = a; iB = b;
        @(negedge clk);
        iSTART = 1'b0; iOP = 2'b01; iA = 24'h5A5A5A; iB = 24'h000001;
        lat = 0;
        while (!oDONE && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #1;
        n_chk++; if (oBUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", oBUSY); else n_pass++;
        n_chk++; if (oDONE !== 1'b0) $display("FAIL reset_done got %b want 0", oDONE); else n_pass++;
        n_chk++; if ({oRESULT, oREM} !== 48'h0) $display("FAIL reset_outputs got %h/%h want 0/0", oRESULT, oREM); else n_pass++;
        n_chk++; if ({oDIV0, oOVF} !== 2'b00) $display("FAIL reset_flags got %b want 00", {oDIV0, oOVF}); else n_pass++;
        repeat (3) @(negedge clk);
        iRST_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add;
        int lat;
        do_op(2'b01, 24'd123456, 24'd654321, lat);
        n_chk++; if (lat !== 3) $display("FAIL add_latency got %0d want 3", lat); else n_pass++;
        n_chk++; if (oBUSY !== 1'b1) $display("FAIL add_busy_in_done got %b want 1", oBUSY); else n_pass++;
        n_chk++; if (oRESULT !== 24'd777777) $display("FAIL add_result got %0d want 777777", oRESULT); else n_pass++;
        n_chk++; if (oREM !== 24'd0) $display("FAIL add_rem got %0d want 0", oREM); else n_pass++;
        n_chk++; if (oOVF !== 1'b0) $display("FAIL add_ovf got %b want 0", oOVF); else n_pass++;
        @(negedge clk);
        n_chk++; if ({oBUSY, oDONE} !== 2'b00) $display("FAIL add_after got busy/done %b want 00", {oBUSY, oDONE}); else n_pass++;
        n_chk++; if (oRESULT !== 24'd777777) $display("FAIL add_hold got %0d want 777777", oRESULT); else n_pass++;
    endtask

    task automatic test_sub;
        int lat;
        do_op(2'b10, 24'd3, 24'd5, lat);
        n_chk++; if (lat !== 3) $display("FAIL sub_latency got %0d want 3", lat); else n_pass++;
        n_chk++; if (oRESULT !== 24'hFFFFFE) $display("FAIL sub_result got %h want fffffe", oRESULT); else n_pass++;
        n_chk++; if (oOVF !== OVF) $display("FAIL sub_ovf got %b want %b", oOVF, OVF); else n_pass++;
        @(negedge clk);
        n_chk++; if (oBUSY !== 1'b0) $display("FAIL sub_busy_after got %b want 0", oBUSY); else n_pass++;
    endtask

    task automatic test_mul;
        int lat;
        do_op(2'b11, 24'd1234, 24'd567, lat);
        n_chk++; if (lat !== 26) $display("FAIL mul_latency got %0d want 26", lat); else n_pass++;
        n_chk++; if (oRESULT !== 24'd699678) $display("FAIL mul_result got %0d want 699678", oRESULT); else n_pass++;
        n_chk++; if ({oREM, oOVF} !== 25'd0) $display("FAIL mul_rem_ovf got %h/%b want 0/0", oREM, oOVF); else n_pass++;
        @(negedge clk);
        do_op(2'b11, 24'h001000, 24'h001000, lat);
        n_chk++; if (oRESULT !== 24'h000000) $display("FAIL mul_wrap_result got %h want 000000", oRESULT); else n_pass++;
        n_chk++; if (oOVF !== OVF) $display("FAIL mul_wrap_ovf got %b want %b", oOVF, OVF); else n_pass++;
        @(negedge clk);
        n_chk++; if (oBUSY !== 1'b0) $display("FAIL mul_busy_after got %b want 0", oBUSY); else n_pass++;
    endtask

    task automatic test_div;
        int lat;
        do_op(2'b00, 24'd1000, 24'd7, lat);
        n_chk++; if (lat !== 26) $display("FAIL div_latency got %0d want 26", lat); else n_pass++;
        n_chk++; if (oRESULT !== 24'd142) $display("FAIL div_quotient got %0d want 142", oRESULT); else n_pass++;
        n_chk++; if (oREM !== 24'd6) $display("FAIL div_rem got %0d want 6", oREM); else n_pass++;
        n_chk++; if ({oDIV0, oOVF} !== 2'b00) $display("FAIL div_flags got %b want 00", {oDIV0, oOVF}); else n_pass++;
        @(negedge clk);
        do_op(2'b00, 24'd5, 24'd0, lat);
        n_chk++; if (lat !== 2) $display("FAIL div0_latency got %0d want 2", lat); else n_pass++;
        n_chk++; if (oRESULT !== 24'hFFFFFF) $display("FAIL div0_result got %h want ffffff", oRESULT); else n_pass++;
        n_chk++; if (oREM !== 24'd5) $display("FAIL div0_rem got %0d want 5", oREM); else n_pass++;
        n_chk++; if (oDIV0 !== 1'b1) $display("FAIL div0_flag got %b want 1", oDIV0); else n_pass++;
        @(negedge clk);
        n_chk++; if (oBUSY !== 1'b0) $display("FAIL div0_busy_after got %b want 0", oBUSY); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat;
        do_op(2'b01, 24'd10, 24'd20, lat);
        n_chk++; if (oRESULT !== 24'd30) $display("FAIL b2b_first got %0d want 30", oRESULT); else n_pass++;
        n_chk++; if (oDIV0 !== 1'b0) $display("FAIL b2b_div0_clear got %b want 0", oDIV0); else n_pass++;
        @(negedge clk);
        do_op(2'b10, 24'd50, 24'd8, lat);
        n_chk++; if (lat !== 3) $display("FAIL b2b_latency got %0d want 3", lat); else n_pass++;
        n_chk++; if (oRESULT !== 24'd42) $display("FAIL b2b_second got %0d want 42", oRESULT); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int dones = 0, lat = 0;
        logic [23:0] res = '0;
        iSTART = 1'b1; iOP = 2'b11; iA = 24'd100; iB = 24'd3;
        @(negedge clk);
        iOP = 2'b01; iA = 24'd1; iB = 24'd1;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (oDONE) begin
                dones++;
                lat = i;
                res = oRESULT;
            end
            iSTART = (i <= 26);
        end
        n_chk++; if (dones !== 1) $display("FAIL ignore_done_count got %0d want 1", dones); else n_pass++;
        n_chk++; if (lat !== 26) $display("FAIL ignore_latency got %0d want 26", lat); else n_pass++;
        n_chk++; if (res !== 24'd300) $display("FAIL ignore_result got %0d want 300", res); else n_pass++;
        n_chk++; if (oBUSY !== 1'b0) $display("FAIL ignore_busy_end got %b want 0", oBUSY); else n_pass++;
    endtask

    task automatic test_reset_abort;
        int lat, dones = 0;
        iSTART = 1'b1; iOP = 2'b00; iA = 24'd1000; iB = 24'd7;
        @(negedge clk);
        iSTART = 1'b0;
        repeat (9) @(negedge clk);
        iRST_n = 1'b0;
        #1;
        n_chk++; if ({oBUSY, oDONE} !== 2'b00) $display("FAIL abort_busy_done got %b want 00", {oBUSY, oDONE}); else n_pass++;
        n_chk++; if ({oRESULT, oREM} !== 48'h0) $display("FAIL abort_outputs got %h/%h want 0/0", oRESULT, oREM); else n_pass++;
        repeat (2) @(negedge clk);
        iRST_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (oDONE) dones++;
        end
        n_chk++; if (dones !== 0) $display("FAIL abort_no_done got %0d want 0", dones); else n_pass++;
        do_op(2'b01, 24'd7, 24'd8, lat);
        n_chk++; if (lat !== 3) $display("FAIL abort_add_latency got %0d want 3", lat); else n_pass++;
        n_chk++; if (oRESULT !== 24'd15) $display("FAIL abort_add_result got %0d want 15", oRESULT); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_mul;
        test_div;
        test_back_to_back;
        test_ignore_start;
        test_reset_abort;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
